// File: rtl/fma16_arb.sv
`default_nettype none
// ============================================================================
// Module      : fma16_arb
// Description : Round-robin arbiter and two-stage issue pipeline sharing one
//               half-precision fused multiply-add datapath (fma16) among
//               NREQ requesters. Optional per-requester sticky flags are
//               enabled by defining FMA16_ARB_STICKY_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module fma16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic [1:0]  roundmode,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    localparam logic [15:0] c_one  = 16'h3c00;
    localparam logic [15:0] c_qnan = 16'h7e00;

    logic [15:0] w_y, w_z;
    logic        w_xs, w_ys, w_zs;
    logic [4:0]  w_xe, w_ye, w_ze;
    logic [9:0]  w_xf, w_yf, w_zf;
    logic        w_xnan, w_ynan, w_znan, w_xinf, w_yinf, w_zinf, w_xzero, w_yzero;
    logic        w_snan, w_pinf, w_inv_op, w_nan, w_invalid;
    logic [10:0] w_xm, w_ym, w_zm;
    logic [5:0]  w_xee, w_yee, w_zee;
    logic [83:0] w_pa, w_za, w_mag;
    logic        w_ps, w_zse, w_sgn;
    logic [6:0]  w_p, w_lsb;
    logic [11:0] w_q, w_qr;
    logic        w_g, w_st, w_inc, w_inexact, w_ovf, w_toinf;
    logic [17:0] w_enc;

    assign w_y = mul ? y : c_one;
    assign w_z = add ? z : 16'h0000;
    assign {w_xs, w_xe, w_xf} = x;
    assign {w_ys, w_ye, w_yf} = w_y;
    assign {w_zs, w_ze, w_zf} = w_z;

    assign w_xnan  = (&w_xe) & (|w_xf);
    assign w_ynan  = (&w_ye) & (|w_yf);
    assign w_znan  = (&w_ze) & (|w_zf);
    assign w_xinf  = (&w_xe) & ~(|w_xf);
    assign w_yinf  = (&w_ye) & ~(|w_yf);
    assign w_zinf  = (&w_ze) & ~(|w_zf);
    assign w_xzero = ~(|w_xe) & ~(|w_xf);
    assign w_yzero = ~(|w_ye) & ~(|w_yf);

    assign w_ps  = w_xs ^ w_ys ^ negp;
    assign w_zse = w_zs ^ negz;

    assign w_snan   = (w_xnan & ~w_xf[9]) | (w_ynan & ~w_yf[9]) | (w_znan & ~w_zf[9]);
    assign w_pinf   = w_xinf | w_yinf;
    assign w_inv_op = (w_xinf & w_yzero) | (w_yinf & w_xzero) | (w_pinf & w_zinf & (w_ps ^ w_zse));
    assign w_nan     = w_xnan | w_ynan | w_znan | w_inv_op;
    assign w_invalid = w_snan | w_inv_op;

    // Exact arithmetic: every operand is placed on a fixed grid of 2^-48
    assign w_xm  = {|w_xe, w_xf};
    assign w_ym  = {|w_ye, w_yf};
    assign w_zm  = {|w_ze, w_zf};
    assign w_xee = (w_xe == 5'd0) ? 6'd1 : {1'b0, w_xe};
    assign w_yee = (w_ye == 5'd0) ? 6'd1 : {1'b0, w_ye};
    assign w_zee = (w_ze == 5'd0) ? 6'd1 : {1'b0, w_ze};
    assign w_pa  = 84'(22'(w_xm) * 22'(w_ym)) << (w_xee + w_yee - 6'd2);
    assign w_za  = 84'(w_zm) << (w_zee + 6'd23);

    always_comb begin
        w_mag = w_pa + w_za;
        w_sgn = w_ps;
        if (w_ps != w_zse) begin
            if (w_pa >= w_za) begin
                w_mag = w_pa - w_za;
            end else begin
                w_mag = w_za - w_pa;
                w_sgn = w_zse;
            end
        end
        if (w_mag == 84'd0) begin
            w_sgn = (w_ps == w_zse) ? w_ps : (roundmode == 2'b10);
        end
    end

    always_comb begin
        w_p = '0;
        for (int i = 0; i < 84; i++) begin
            if (w_mag[i]) w_p = 7'(i);
        end
    end

    // Quantum of the result: 2^-24 for subnormals, else 10 bits below the MSB
    assign w_lsb     = (w_p >= 7'd34) ? (w_p - 7'd10) : 7'd24;
    assign w_q       = 12'(w_mag >> w_lsb);
    assign w_g       = w_mag[w_lsb - 7'd1];
    assign w_st      = |(w_mag & ((84'd1 << (w_lsb - 7'd1)) - 84'd1));
    assign w_inexact = w_g | w_st;

    always_comb begin
        case (roundmode)
            2'b00:   w_inc = 1'b0;
            2'b01:   w_inc = w_g & (w_st | w_q[0]);
            2'b10:   w_inc = w_sgn & w_inexact;
            default: w_inc = ~w_sgn & w_inexact;
        endcase
    end

    // Exponent and mantissa fuse so a rounding carry bumps the exponent
    assign w_qr    = w_q + {11'd0, w_inc};
    assign w_enc   = ((18'(w_lsb) - 18'd24) << 10) + 18'(w_qr);
    assign w_ovf   = (w_enc >= 18'h07c00);
    assign w_toinf = (roundmode == 2'b01) | ((roundmode == 2'b10) & w_sgn) |
                     ((roundmode == 2'b11) & ~w_sgn);

    always_comb begin
        result = {w_sgn, w_enc[14:0]};
        flags  = {2'b00, w_inexact & (w_p < 7'd34), w_inexact};
        if (w_nan) begin
            result = c_qnan;
            flags  = {w_invalid, 3'b000};
        end else if (w_pinf) begin
            result = {w_ps, 15'h7c00};
            flags  = 4'b0000;
        end else if (w_zinf) begin
            result = {w_zse, 15'h7c00};
            flags  = 4'b0000;
        end else if (w_ovf) begin
            result = w_toinf ? {w_sgn, 15'h7c00} : {w_sgn, 15'h7bff};
            flags  = 4'b0101;
        end
    end
endmodule

module fma16_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [16*NREQ-1:0]  req_x,
    input  logic [16*NREQ-1:0]  req_y,
    input  logic [16*NREQ-1:0]  req_z,
    input  logic [6*NREQ-1:0]   req_ctrl,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_result,
    output logic [3:0]          rsp_flags,
    output logic [IDW-1:0]      rsp_id,
    output logic [4*NREQ-1:0]   sticky_flags,
    input  logic [NREQ-1:0]     flag_clr
);
    logic           r_s1_valid, r_s2_valid;
    logic [IDW-1:0] r_s1_id, r_s2_id, r_last;
    logic [15:0]    r_s1_x, r_s1_y, r_s1_z, r_s2_result;
    logic [5:0]     r_s1_ctrl;
    logic [3:0]     r_s2_flags;
    logic           w_s2_adv, w_s1_free, w_found, w_accept;
    logic [IDW-1:0] w_gnt_id;
    logic [15:0]    w_sel_x, w_sel_y, w_sel_z, w_fma_result;
    logic [5:0]     w_sel_ctrl;
    logic [3:0]     w_fma_flags;

    assign w_s2_adv  = r_s1_valid & (~r_s2_valid | rsp_ready);
    assign w_s1_free = ~r_s1_valid | w_s2_adv;

    // Two passes: indices above the pointer first, then wrap to the bottom
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i > int'(r_last))) begin
                w_found  = 1'b1;
                w_gnt_id = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i <= int'(r_last))) begin
                w_found  = 1'b1;
                w_gnt_id = IDW'(i);
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_z    = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                req_ready[i] = w_found & w_s1_free;
                w_sel_x      = req_x[16*i +: 16];
                w_sel_y      = req_y[16*i +: 16];
                w_sel_z      = req_z[16*i +: 16];
                w_sel_ctrl   = req_ctrl[6*i +: 6];
            end
        end
    end

    assign w_accept = |req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_last      <= IDW'(NREQ - 1);
            r_s1_id     <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_z      <= '0;
            r_s1_ctrl   <= '0;
            r_s2_id     <= '0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_id    <= w_gnt_id;
                r_s1_x     <= w_sel_x;
                r_s1_y     <= w_sel_y;
                r_s1_z     <= w_sel_z;
                r_s1_ctrl  <= w_sel_ctrl;
                r_last     <= w_gnt_id;
            end else if (w_s2_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_adv) begin
                r_s2_valid  <= 1'b1;
                r_s2_id     <= r_s1_id;
                r_s2_result <= w_fma_result;
                r_s2_flags  <= w_fma_flags;
            end else if (r_s2_valid && rsp_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    fma16 u_fma16 (
        .x         (r_s1_x),
        .y         (r_s1_y),
        .z         (r_s1_z),
        .roundmode (r_s1_ctrl[5:4]),
        .mul       (r_s1_ctrl[3]),
        .add       (r_s1_ctrl[2]),
        .negp      (r_s1_ctrl[1]),
        .negz      (r_s1_ctrl[0]),
        .result    (w_fma_result),
        .flags     (w_fma_flags)
    );

    assign rsp_valid  = r_s2_valid;
    assign rsp_result = r_s2_result;
    assign rsp_flags  = r_s2_flags;
    assign rsp_id     = r_s2_id;

`ifdef FMA16_ARB_STICKY_FLAGS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sticky
        logic [3:0] r_sticky;
        // A clear outranks a same-cycle accumulation
        always_ff @(posedge clk) begin
            if (reset || flag_clr[gi]) begin
                r_sticky <= 4'b0000;
            end else if (r_s2_valid && rsp_ready && (r_s2_id == IDW'(gi))) begin
                r_sticky <= r_sticky | r_s2_flags;
            end
        end
        assign sticky_flags[4*gi +: 4] = r_sticky;
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = ^flag_clr;
    assign sticky_flags = '0;
`endif
endmodule

`default_nettype wire
